// File: rtl/cpu_pkg.sv
// Shared CPU encodings: PC update style, branch condition, opcodes, sequencer state.
package cpu_pkg;

    localparam int INSTR_WIDTH  = 16;
    localparam int ADDR_WIDTH   = 6;
    localparam int RETIRE_WIDTH = 16;

    // PC update style (also decoded by programCounter)
    localparam logic [1:0] PS_HOLD = 2'd0;
    localparam logic [1:0] PS_INC  = 2'd1;
    localparam logic [1:0] PS_REL  = 2'd2;
    localparam logic [1:0] PS_ABS  = 2'd3;

    // Branch condition
    localparam logic [1:0] BC_ZERO   = 2'd0;
    localparam logic [1:0] BC_NZERO  = 2'd1;
    localparam logic [1:0] BC_ALWAYS = 2'd3;

    // Opcodes (IR[15:12]); 0x1..0x9 are ALU ops passed straight through
    localparam logic [3:0] OPC_NOP     = 4'h0;
    localparam logic [3:0] OPC_ALU_MIN = 4'h1;
    localparam logic [3:0] OPC_ALU_MAX = 4'h9;
    localparam logic [3:0] OPC_BZ      = 4'hA;
    localparam logic [3:0] OPC_BNZ     = 4'hB;
    localparam logic [3:0] OPC_BRA     = 4'hC;
    localparam logic [3:0] OPC_JMP     = 4'hD;
    localparam logic [3:0] OPC_HALT    = 4'hE;
    localparam logic [3:0] OPC_ILLEGAL = 4'hF;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decode into PC controls and register-file write controls.
import cpu_pkg::*;

module instr_decoder (
    input  logic [3:0] i_opcode,
    output logic [1:0] o_ps,
    output logic [1:0] o_bc,
    output logic [3:0] o_alu_op,
    output logic       o_rf_write_en,
    output logic       o_is_halt,
    output logic       o_is_illegal
);

    // Opcode -> controls; anything not named behaves like NOP
    always_comb begin
        o_ps          = PS_INC;
        o_bc          = BC_ALWAYS;
        o_alu_op      = 4'h0;
        o_rf_write_en = 1'b0;
        o_is_halt     = 1'b0;
        o_is_illegal  = 1'b0;
        if (i_opcode >= OPC_ALU_MIN && i_opcode <= OPC_ALU_MAX) begin
            o_alu_op      = i_opcode;
            o_rf_write_en = 1'b1;
        end else begin
            case (i_opcode)
                OPC_BZ:      begin o_ps = PS_REL; o_bc = BC_ZERO;  end
                OPC_BNZ:     begin o_ps = PS_REL; o_bc = BC_NZERO; end
                OPC_BRA:     o_ps = PS_REL;
                OPC_JMP:     o_ps = PS_ABS;
                OPC_HALT:    begin o_ps = PS_HOLD; o_is_halt = 1'b1; end
                OPC_ILLEGAL: o_is_illegal = 1'b1;
                default:     ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer: fetches via the PC address, latches IR, and drives
// PC/register-file controls for exactly one EXEC cycle per instruction.
import cpu_pkg::*;

module fetch_sequencer (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   pc_addr,
    output logic [ADDR_WIDTH-1:0]   imem_addr,
    output logic                    imem_req,
    input  logic                    imem_valid,
    input  logic [INSTR_WIDTH-1:0]  imem_data,
    output logic [1:0]              ps,
    output logic [1:0]              bc,
    output logic [3:0]              aa,
    output logic [3:0]              ba,
    output logic [3:0]              dr,
    output logic [3:0]              alu_op,
    output logic                    rf_write_en,
    output logic                    halted,
    output logic                    illegal_op,
    output logic [RETIRE_WIDTH-1:0] retired
);

    seq_state_t              r_state;
    logic [INSTR_WIDTH-1:0]  r_ir;
    logic                    r_illegal;
    logic [RETIRE_WIDTH-1:0] r_retired;

    logic [1:0] w_ps;
    logic [1:0] w_bc;
    logic [3:0] w_alu_op;
    logic       w_we;
    logic       w_is_halt;
    logic       w_is_illegal;
    logic       w_exec;

    instr_decoder u_dec (
        .i_opcode      (r_ir[15:12]),
        .o_ps          (w_ps),
        .o_bc          (w_bc),
        .o_alu_op      (w_alu_op),
        .o_rf_write_en (w_we),
        .o_is_halt     (w_is_halt),
        .o_is_illegal  (w_is_illegal)
    );

    assign w_exec = (r_state == EXEC);

    // Sequencer FSM plus IR, sticky illegal flag and saturating retire count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= FETCH;
            r_ir      <= '0;
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (imem_valid) begin
                        r_ir    <= imem_data;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_state <= w_is_halt ? HALT : FETCH;
                    if (w_is_illegal)
                        r_illegal <= 1'b1;
                    if (r_retired != {RETIRE_WIDTH{1'b1}})
                        r_retired <= r_retired + 1'b1;
                end
                HALT:    r_state <= HALT;
                default: r_state <= FETCH;
            endcase
        end
    end

    // PC is held with an unconditional HOLD everywhere except EXEC, where
    // the decode drives it combinationally so the PC samples it at EXEC's end
    always_comb begin
        ps          = w_exec ? w_ps     : PS_HOLD;
        bc          = w_exec ? w_bc     : BC_ALWAYS;
        alu_op      = w_exec ? w_alu_op : 4'h0;
        rf_write_en = w_exec & w_we;
    end

    assign imem_addr  = pc_addr;
    assign imem_req   = (r_state == FETCH);
    assign halted     = (r_state == HALT);
    assign dr         = r_ir[11:8];
    assign aa         = r_ir[7:4];
    assign ba         = r_ir[3:0];
    assign illegal_op = r_illegal;
    assign retired    = r_retired;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench: a simple PC and register file surround the sequencer;
// expected values are hand-computed constants.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  pc_addr;
    logic [5:0]  imem_addr;
    logic        imem_req;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic [1:0]  ps, bc;
    logic [3:0]  aa, ba, dr, alu_op;
    logic        rf_write_en, halted, illegal_op;
    logic [15:0] retired;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] regs [16];

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .pc_addr     (pc_addr),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_valid  (imem_valid),
        .imem_data   (imem_data),
        .ps          (ps),
        .bc          (bc),
        .aa          (aa),
        .ba          (ba),
        .dr          (dr),
        .alu_op      (alu_op),
        .rf_write_en (rf_write_en),
        .halted      (halted),
        .illegal_op  (illegal_op),
        .retired     (retired)
    );

    // Environment PC: follows ps/bc with the register file as branch source
    logic       cond_ok;
    logic [7:0] off;
    always_comb begin
        off = {aa, ba};
        case (bc)
            2'd0:    cond_ok = (regs[dr] == 16'h0);
            2'd1:    cond_ok = (regs[dr] != 16'h0);
            default: cond_ok = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) pc_addr <= 6'd0;
        else begin
            case (ps)
                2'd1: pc_addr <= pc_addr + 6'd1;
                2'd2: pc_addr <= cond_ok ? pc_addr + off[5:0] + 6'd1 : pc_addr + 6'd1;
                2'd3: pc_addr <= cond_ok ? regs[aa][5:0] : pc_addr + 6'd1;
                default: pc_addr <= pc_addr;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Zero-wait fetch; returns with the DUT in EXEC
    task automatic fetch(input logic [15:0] d);
        imem_valid = 1'b1;
        imem_data  = d;
        tick();
        imem_valid = 1'b0;
        imem_data  = 16'h0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 16'h0;
        regs[2] = 16'h0015;
        reset = 1'b1; imem_valid = 1'b0; imem_data = 16'h0;
        tick();
        reset = 1'b0;

        // reset state
        check("rst_req",  imem_req, 1);
        check("rst_ps",   ps, 0);
        check("rst_bc",   bc, 3);
        check("rst_we",   rf_write_en, 0);
        check("rst_halt", halted, 0);
        check("rst_ret",  retired, 0);
        check("rst_ill",  illegal_op, 0);
        check("rst_addr", imem_addr, 0);

        // ALU op, zero-wait memory
        fetch(16'h1123);
        check("alu_we",  rf_write_en, 1);
        check("alu_op",  alu_op, 1);
        check("alu_dr",  dr, 1);
        check("alu_ps",  ps, 1);
        check("alu_bc",  bc, 3);
        check("alu_req", imem_req, 0);
        tick();
        check("alu_ret",   retired, 1);
        check("alu_we0",   rf_write_en, 0);
        check("alu_op0",   alu_op, 0);
        check("alu_addr",  imem_addr, 1);

        // memory stall: PC must hold
        for (int i = 0; i < 3; i++) begin
            imem_valid = 1'b0;
            tick();
            check("stall_ps",   ps, 0);
            check("stall_bc",   bc, 3);
            check("stall_req",  imem_req, 1);
            check("stall_addr", imem_addr, 1);
        end
        // stray data with valid low must not load
        check("stall_dr", dr, 1);

        // NOPs to bring the PC to 5
        for (int i = 0; i < 4; i++) begin
            fetch(16'h0000);
            check("nop_ps", ps, 1);
            tick();
        end
        check("nop_addr", imem_addr, 5);
        check("nop_ret",  retired, 5);

        // BZ -2 with reg0 == 0
        fetch(16'hA0FE);
        check("bz_ps", ps, 2);
        check("bz_bc", bc, 0);
        check("bz_aa", aa, 4'hF);
        check("bz_ba", ba, 4'hE);
        check("bz_we", rf_write_en, 0);
        tick();
        check("bz_addr", imem_addr, 4);
        check("bz_ret",  retired, 6);

        // JMP reg2
        fetch(16'hD020);
        check("jmp_ps", ps, 3);
        check("jmp_bc", bc, 3);
        check("jmp_aa", aa, 2);
        tick();
        check("jmp_addr", imem_addr, 6'h15);

        // illegal opcode: NOP behaviour plus sticky flag
        fetch(16'hF000);
        check("ill_ps", ps, 1);
        check("ill_we", rf_write_en, 0);
        tick();
        check("ill_flag", illegal_op, 1);
        check("ill_addr", imem_addr, 6'h16);
        fetch(16'h2345);
        check("ill_alu_op", alu_op, 2);
        tick();
        check("ill_sticky", illegal_op, 1);
        check("ill_ret",    retired, 9);

        // reset during FETCH with a valid response: dropped
        reset = 1'b1; imem_valid = 1'b1; imem_data = 16'h1123;
        tick();
        reset = 1'b0; imem_valid = 1'b0; imem_data = 16'h0;
        check("rf_dr",   dr, 0);
        check("rf_ret",  retired, 0);
        check("rf_ill",  illegal_op, 0);
        check("rf_req",  imem_req, 1);
        check("rf_addr", imem_addr, 0);

        // HALT
        fetch(16'hE000);
        check("halt_ps",   ps, 0);
        check("halt_bc",   bc, 3);
        check("halt_h0",   halted, 0);
        tick();
        for (int i = 0; i < 10; i++) begin
            imem_valid = i[0];
            imem_data  = 16'h1123;
            check("halt_h",    halted, 1);
            check("halt_req",  imem_req, 0);
            check("halt_ps_h", ps, 0);
            check("halt_we",   rf_write_en, 0);
            check("halt_ret",  retired, 1);
            check("halt_addr", imem_addr, 0);
            tick();
        end
        imem_valid = 1'b0; imem_data = 16'h0;

        // reset pulse leaves HALT
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("post_h",    halted, 0);
        check("post_req",  imem_req, 1);
        check("post_addr", imem_addr, 0);
        check("post_ret",  retired, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
